// File: rtl/led_scanner_pkg.sv
// Shared types and helpers for the LED scanner.
package led_scanner_pkg;

    typedef enum logic [1:0] {
        BOUNCE    = 2'd0,
        WRAP_UP   = 2'd1,
        WRAP_DOWN = 2'd2,
        FILL      = 2'd3
    } scan_mode_t;

    // Position register width: must hold 0..n for the FILL level.
    function automatic int pos_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_scanner_if.sv
// Control/status bundle between the board switches/keys and the LED scanner.
interface led_scanner_if
    import led_scanner_pkg::*;
#(
    parameter int NUM_LEDS   = 10,
    parameter int SPEED_BITS = 2
);
    localparam int PW = pos_width(NUM_LEDS);

    logic [1:0]            mode;
    logic [SPEED_BITS-1:0] speed;
    logic                  pause;
    logic                  step;
    logic [NUM_LEDS-1:0]   leds;
    logic [PW-1:0]         pos;
    logic                  dir_up;
    logic                  tick;
    logic                  end_pulse;

    modport master (
        output mode, speed, pause, step,
        input  leds, pos, dir_up, tick, end_pulse
    );

    modport slave (
        input  mode, speed, pause, step,
        output leds, pos, dir_up, tick, end_pulse
    );

endinterface

// File: rtl/led_scanner_tick.sv
// Clock-enable prescaler: one-cycle tick every 2**(TICK_WIDTH-speed) cycles,
// frozen while paused, where each step pulse yields exactly one tick.
module led_scanner_tick #(
    parameter int TICK_WIDTH = 22,
    parameter int SPEED_BITS = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [SPEED_BITS-1:0] speed,
    input  logic                  pause,
    input  logic                  step,
    output logic                  tick
);
    logic [TICK_WIDTH-1:0] cnt_reg;
    logic                  tick_reg;
    logic [TICK_WIDTH:0]   span;
    logic [TICK_WIDTH-1:0] term;

    assign span = {1'b1, {TICK_WIDTH{1'b0}}} >> speed;
    assign term = TICK_WIDTH'(span - (TICK_WIDTH + 1)'(1));

    // >= rather than == so a speed-up mid-count terminates on the next cycle
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (pause) begin
            tick_reg <= step;
        end else if (cnt_reg >= term) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + TICK_WIDTH'(1);
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/led_scanner.sv
// Multi-mode LED scanning pattern generator (bounce, wrap up/down, fill).
// Define LED_SCANNER_TRAIL_EN to add a one-LED comet trail in the one-hot modes.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int NUM_LEDS   = 10,
    parameter int TICK_WIDTH = 22,
    parameter int SPEED_BITS = 2
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    led_scanner_if.slave  bus
);
    localparam int            PW       = pos_width(NUM_LEDS);
    localparam logic [PW-1:0] POS_LAST = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] POS_FULL = PW'(NUM_LEDS);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);

    logic tick_w;

    led_scanner_tick #(
        .TICK_WIDTH (TICK_WIDTH),
        .SPEED_BITS (SPEED_BITS)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .speed    (bus.speed),
        .pause    (bus.pause),
        .step     (bus.step),
        .tick     (tick_w)
    );

    scan_mode_t    mode_req;
    scan_mode_t    mode_reg, mode_next;
    logic [PW-1:0] pos_reg, pos_next;
    logic          dir_reg, dir_next;
    logic [PW-1:0] top_end;
    logic          end_hit;

    assign mode_req = scan_mode_t'(bus.mode);
    assign top_end  = (mode_req == FILL) ? POS_FULL : POS_LAST;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mode_reg <= BOUNCE;
            pos_reg  <= '0;
            dir_reg  <= 1'b1;
        end else begin
            mode_reg <= mode_next;
            pos_reg  <= pos_next;
            dir_reg  <= dir_next;
        end
    end

    always_comb begin
        mode_next = mode_reg;
        pos_next  = pos_reg;
        dir_next  = dir_reg;
        end_hit   = 1'b0;
        if (tick_w) begin
            mode_next = mode_req;
            if (mode_req != FILL && pos_reg == POS_FULL) begin
                // Leaving FILL at full level: restart one-hot scan from LED 0
                pos_next = '0;
                dir_next = 1'b1;
            end else begin
                case (mode_req)
                    WRAP_UP: begin
                        dir_next = 1'b1;
                        if (pos_reg == POS_LAST) begin
                            pos_next = '0;
                            end_hit  = 1'b1;
                        end else begin
                            pos_next = pos_reg + POS_ONE;
                        end
                    end
                    WRAP_DOWN: begin
                        dir_next = 1'b0;
                        if (pos_reg == '0) begin
                            pos_next = POS_LAST;
                            end_hit  = 1'b1;
                        end else begin
                            pos_next = pos_reg - POS_ONE;
                        end
                    end
                    default: begin
                        // BOUNCE and FILL reflect off 0 and top_end without dwelling
                        if (dir_reg) begin
                            if (pos_reg == top_end) begin
                                pos_next = top_end - POS_ONE;
                                dir_next = 1'b0;
                                end_hit  = 1'b1;
                            end else begin
                                pos_next = pos_reg + POS_ONE;
                            end
                        end else begin
                            if (pos_reg == '0) begin
                                pos_next = POS_ONE;
                                dir_next = 1'b1;
                                end_hit  = 1'b1;
                            end else begin
                                pos_next = pos_reg - POS_ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef LED_SCANNER_TRAIL_EN
    logic [PW-1:0] prev_pos_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            prev_pos_reg <= '0;
        end else if (tick_w) begin
            prev_pos_reg <= pos_reg;
        end
    end
`endif

    logic [NUM_LEDS-1:0] leds_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            logic lit_head;
            logic lit_fill;
            assign lit_head = (pos_reg == PW'(gi));
            assign lit_fill = (pos_reg > PW'(gi));
`ifdef LED_SCANNER_TRAIL_EN
            logic lit_tail;
            assign lit_tail   = (prev_pos_reg == PW'(gi));
            assign leds_w[gi] = (mode_reg == FILL) ? lit_fill : (lit_head | lit_tail);
`else
            assign leds_w[gi] = (mode_reg == FILL) ? lit_fill : lit_head;
`endif
        end
    endgenerate

    assign bus.leds      = leds_w;
    assign bus.pos       = pos_reg;
    assign bus.dir_up    = dir_reg;
    assign bus.tick      = tick_w;
    assign bus.end_pulse = end_hit;

endmodule

// File: tb/tb_led_scanner.sv
// Self-checking bench for led_scanner (NUM_LEDS=10, TICK_WIDTH=3, SPEED_BITS=2).
module tb_led_scanner;
    import led_scanner_pkg::*;

    localparam int N  = 10;
    localparam int TW = 3;
    localparam int SB = 2;
`ifdef LED_SCANNER_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    led_scanner_if #(.NUM_LEDS(N), .SPEED_BITS(SB)) bus ();

    led_scanner #(
        .NUM_LEDS   (N),
        .TICK_WIDTH (TW),
        .SPEED_BITS (SB)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position as integer arithmetic on a line of LEDs
    int m_cnt, m_pos, m_dir, m_mode, m_prev;
    bit m_tick;
    bit m_valid = 1'b0;

    function automatic void model_move(input int p, input int d, input int md,
                                       output int np, output int nd, output bit ev);
        int top;
        np = p; nd = d; ev = 1'b0;
        top = (md == 3) ? N : N - 1;
        if (md != 3 && p == N) begin
            np = 0; nd = 1;
        end else if (md == 1) begin
            np = (p + 1) % N; nd = 1; ev = (np == 0);
        end else if (md == 2) begin
            np = (p + N - 1) % N; nd = 0; ev = (np == N - 1);
        end else begin
            np = p + (d != 0 ? 1 : -1);
            if (np > top) begin
                np = top - 1; nd = 0; ev = 1'b1;
            end else if (np < 0) begin
                np = 1; nd = 1; ev = 1'b1;
            end
        end
    endfunction

    function automatic int model_leds();
        int v;
        if (m_mode == 3) v = (1 << m_pos) - 1;
        else v = (1 << m_pos) | (TRAIL ? (1 << m_prev) : 0);
        return v & ((1 << N) - 1);
    endfunction

    always @(posedge CLOCK_50) begin
        int np, nd, term;
        bit ev;
        if (reset) begin
            m_cnt = 0; m_tick = 0; m_pos = 0; m_dir = 1; m_mode = 0; m_prev = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_tick) begin
                model_move(m_pos, m_dir, int'(bus.mode), np, nd, ev);
                m_prev = m_pos;
                m_pos  = np;
                m_dir  = nd;
                m_mode = int'(bus.mode);
            end
            term = ((1 << TW) >> bus.speed) - 1;
            if (bus.pause) m_tick = bus.step;
            else if (m_cnt >= term) begin m_cnt = 0; m_tick = 1; end
            else begin m_cnt++; m_tick = 0; end
        end
    end

    always @(negedge CLOCK_50) begin
        int np, nd;
        bit ev;
        if (m_valid) begin
            model_move(m_pos, m_dir, int'(bus.mode), np, nd, ev);
            check("m_tick",   bus.tick,      int'(m_tick));
            check("m_pos",    bus.pos,       m_pos);
            check("m_dir",    bus.dir_up,    m_dir);
            check("m_leds",   bus.leds,      model_leds());
            check("m_endp",   bus.end_pulse, int'(m_tick && ev));
        end
    end

    // Returns at the negedge one cycle after a tick; ep is end_pulse seen during the tick
    task automatic do_tick(output bit ep);
        int n = 0;
        ep = 1'b0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (bus.tick !== 1'b1 && n < 200);
        if (bus.tick !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout actual=no_tick required=tick t=%0t", $time);
        end
        ep = bus.end_pulse;
        @(negedge CLOCK_50);
    endtask

    task automatic do_ticks(input int n, output bit ep);
        ep = 1'b0;
        for (int i = 0; i < n; i++) do_tick(ep);
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        @(negedge CLOCK_50);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ep;
        int cnt_t;
        bus.mode = 2'd0; bus.speed = '0; bus.pause = 1'b0; bus.step = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_pos",  bus.pos, 0);
        check("rst_dir",  bus.dir_up, 1);
        check("rst_leds", bus.leds, 'h001);
        check("rst_tick", bus.tick, 0);
        check("rst_endp", bus.end_pulse, 0);
        #1 reset = 1'b0;

        // Bounce up to the top end and back
        do_ticks(9, ep);
        check("t1_ep_to9",  ep, 0);
        check("t1_pos9",    bus.pos, 9);
        check("t1_leds9",   bus.leds, TRAIL ? 'h300 : 'h200);
        do_tick(ep);
        check("t1_ep_top",  ep, 1);
        check("t1_pos8",    bus.pos, 8);
        check("t1_dir8",    bus.dir_up, 0);
        check("t1_leds8",   bus.leds, TRAIL ? 'h300 : 'h100);
        do_ticks(8, ep);
        check("t1_pos0",    bus.pos, 0);
        do_tick(ep);
        check("t1_ep_bot",  ep, 1);
        check("t1_pos1",    bus.pos, 1);
        check("t1_dir1",    bus.dir_up, 1);

        // Wrap up, then wrap down
        #1 bus.mode = 2'd1;
        do_ticks(6, ep);
        check("t2_pos7",    bus.pos, 7);
        do_ticks(2, ep);
        check("t2_pos9",    bus.pos, 9);
        do_tick(ep);
        check("t2_ep_wrap", ep, 1);
        check("t2_pos0",    bus.pos, 0);
        check("t2_dir",     bus.dir_up, 1);
        do_tick(ep);
        #1 bus.mode = 2'd2;
        do_tick(ep);
        check("t2_dn_pos0", bus.pos, 0);
        check("t2_dn_dir",  bus.dir_up, 0);
        do_tick(ep);
        check("t2_ep_dn",   ep, 1);
        check("t2_dn_pos9", bus.pos, 9);

        // Fill levels
        pulse_reset();
        bus.mode = 2'd3;
        do_tick(ep);
        check("t3_leds1",   bus.leds, 'h001);
        do_tick(ep);
        check("t3_leds2",   bus.leds, 'h003);
        do_ticks(8, ep);
        check("t3_pos10",   bus.pos, 10);
        check("t3_leds10",  bus.leds, 'h3FF);
        do_tick(ep);
        check("t3_ep_full", ep, 1);
        check("t3_pos9",    bus.pos, 9);
        check("t3_leds9",   bus.leds, 'h1FF);
        pulse_reset();
        bus.mode = 2'd3;
        do_ticks(10, ep);
        #1 bus.mode = 2'd0;
        do_tick(ep);
        check("t3_clamp_ep",   ep, 0);
        check("t3_clamp_pos",  bus.pos, 0);
        check("t3_clamp_leds", bus.leds, 'h001);
        check("t3_clamp_dir",  bus.dir_up, 1);

        // Speed-up mid-count (counter at 5 of 7)
        repeat (4) @(negedge CLOCK_50);
        #1 bus.speed = 2'd2;
        @(negedge CLOCK_50); check("t4_tick_a", bus.tick, 1);
        @(negedge CLOCK_50); check("t4_tick_b", bus.tick, 0);
        @(negedge CLOCK_50); check("t4_tick_c", bus.tick, 1);
        @(negedge CLOCK_50); check("t4_tick_d", bus.tick, 0);

        // Pause and single-step
        #1 bus.speed = 2'd0;
        pulse_reset();
        do_ticks(3, ep);
        #1 bus.pause = 1'b1;
        cnt_t = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK_50);
            if (bus.tick === 1'b1) cnt_t++;
        end
        check("t5_pause_ticks", cnt_t, 0);
        check("t5_pause_pos",   bus.pos, 3);
        #1 bus.step = 1'b1;
        cnt_t = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLOCK_50);
            if (bus.tick === 1'b1) cnt_t++;
            if (i == 0) #1 bus.step = 1'b0;
        end
        check("t5_step_ticks", cnt_t, 1);
        check("t5_step_pos",   bus.pos, 4);
        #1 bus.pause = 1'b0; bus.step = 1'b1;
        cnt_t = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            if (bus.tick === 1'b1) cnt_t++;
            if (i == 0) #1 bus.step = 1'b0;
        end
        check("t5_unpaused_step", cnt_t, 0);
        @(negedge CLOCK_50);
        check("t6_tick_at4", bus.tick, 1);
        check("t6_pos4",     bus.pos, 4);

        // Reset coinciding with a tick
        #1 reset = 1'b1;
        @(negedge CLOCK_50);
        check("t6_pos",  bus.pos, 0);
        check("t6_dir",  bus.dir_up, 1);
        check("t6_leds", bus.leds, 'h001);
        check("t6_tick", bus.tick, 0);
        #1 reset = 1'b0;

        // Mixed run under the model alone
        for (int k = 0; k < 8; k++) begin
            #1 bus.mode = 2'(k % 4); bus.speed = 2'(k % 3);
            bus.pause = (k == 5);
            repeat (40) @(negedge CLOCK_50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
